// File: rtl/tuser_pkg.sv
// Shared definitions for the tuple/tuser conversion stages.
// Tuple width, default stream width and the output merger FSM states.
package tuser_pkg;

   localparam int TUPLE_W    = 128;
   localparam int DATA_W_DEF = 256;

   typedef enum logic {
      SOP  = 1'b0,
      BODY = 1'b1
   } state_t;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXIS register slice: registered ready upstream,
// registered valid/payload downstream, full throughput.
module axis_skid_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   input  logic         out_ready
);

   logic         skid_vld_q;
   logic         skid_vld_d;
   logic [W-1:0] skid_q;
   logic [W-1:0] skid_d;
   logic         out_vld_d;
   logic [W-1:0] out_d;
   logic         in_fire;

   always_comb begin
      out_vld_d  = out_valid;
      out_d      = out_data;
      skid_vld_d = skid_vld_q;
      skid_d     = skid_q;
      in_fire    = in_valid & in_ready;
      if (!out_valid || out_ready) begin
         // skid entry is older than anything arriving now
         if (skid_vld_q) begin
            out_vld_d  = 1'b1;
            out_d      = skid_q;
            skid_vld_d = 1'b0;
         end else if (in_fire) begin
            out_vld_d = 1'b1;
            out_d     = in_data;
         end else begin
            out_vld_d = 1'b0;
         end
      end else if (in_fire) begin
         skid_vld_d = 1'b1;
         skid_d     = in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         skid_vld_q <= 1'b0;
         skid_q     <= '0;
         in_ready   <= 1'b0;
      end else begin
         out_valid  <= out_vld_d;
         out_data   <= out_d;
         skid_vld_q <= skid_vld_d;
         skid_q     <= skid_d;
         in_ready   <= ~skid_vld_d;
      end
   end

endmodule

// File: rtl/tuser_out_fsm.sv
// Output-side tuple merger: buffers SDNet output tuples and places
// each one in tuser of the first beat of the matching packet.
module tuser_out_fsm
   import tuser_pkg::*;
#(
   parameter  int TUPLE_DEPTH = 4,
   parameter  int DATA_W      = DATA_W_DEF,
   localparam int KEEP_W      = DATA_W / 8
) (
   input  logic               tout_aclk,
   input  logic               tout_arst,
   input  logic               tout_valid,
   input  logic [TUPLE_W-1:0] tout_data,
   input  logic               tout_s_avalid,
   input  logic [DATA_W-1:0]  tout_s_adata,
   input  logic [KEEP_W-1:0]  tout_s_atkeep,
   input  logic               tout_s_atlast,
   output logic               tout_s_aready,
   output logic               tout_m_avalid,
   output logic [DATA_W-1:0]  tout_m_adata,
   output logic [KEEP_W-1:0]  tout_m_atkeep,
   output logic [TUPLE_W-1:0] tout_m_atuser,
   output logic               tout_m_atlast,
   input  logic               tout_m_aready,
   output logic               tout_tuple_drop
);

   localparam int AW = $clog2(TUPLE_DEPTH);
   localparam int PW = DATA_W + KEEP_W + TUPLE_W + 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(TUPLE_DEPTH);

   logic [TUPLE_W-1:0] mem [TUPLE_DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [AW:0]        count;
   logic               fifo_empty;
   logic               fifo_full;
   logic               push;
   logic               pop;

   state_t             state;
   state_t             state_nxt;
   logic               sb_ready;
   logic               in_fire;
   logic [TUPLE_W-1:0] beat_user;
   logic [PW-1:0]      sb_in;
   logic [PW-1:0]      sb_out;

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == FULL_CNT);

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      beat_user = '0;
      // a packet start may only enter once its tuple is buffered
      tout_s_aready = sb_ready & ((state == BODY) | ~fifo_empty);
      in_fire       = tout_s_avalid & tout_s_aready;
      unique case (state)
         SOP: begin
            if (in_fire) begin
               pop       = 1'b1;
               beat_user = mem[rd_ptr];
               if (!tout_s_atlast) state_nxt = BODY;
            end
         end
         BODY: begin
            if (in_fire && tout_s_atlast) state_nxt = SOP;
         end
      endcase
      push            = tout_valid & (~fifo_full | pop);
      tout_tuple_drop = tout_valid & ~push;
   end

   always_ff @(posedge tout_aclk or negedge tout_arst) begin
      if (!tout_arst) begin
         state  <= SOP;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         state <= state_nxt;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge tout_aclk) begin
      if (push) mem[wr_ptr] <= tout_data;
   end

   assign sb_in = {tout_s_adata, tout_s_atkeep, beat_user, tout_s_atlast};

   axis_skid_buf #(
      .W (PW)
   ) u_skid (
      .clk       (tout_aclk),
      .rst_n     (tout_arst),
      .in_valid  (tout_s_avalid & tout_s_aready),
      .in_data   (sb_in),
      .in_ready  (sb_ready),
      .out_valid (tout_m_avalid),
      .out_data  (sb_out),
      .out_ready (tout_m_aready)
   );

   assign {tout_m_adata, tout_m_atkeep,
           tout_m_atuser, tout_m_atlast} = sb_out;

endmodule
